// File: rtl/adder_pkg.sv
// ============================================================================
// adder_pkg : shared state encoding and default width for the serial adder.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam int c_default_width = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// full_adder : 1-bit full adder cell, the bit-slice of the serial adder.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : LSB-first bit-serial adder, one bit pair per clock through a
//                single full_adder cell; registered sum/carry-out with done pulse.
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             C_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic [WIDTH-1:0]   w_sum_next;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_fa_sum;
  logic               w_fa_carry;
  logic               w_last;

  full_adder u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_carry),
    .o_s (w_fa_sum),
    .o_c (w_fa_carry)
  );

  assign w_last = (r_state == SHIFT) && (r_cnt == c_last);

  // New sum bit enters at the MSB so the LSB-first result lands in order.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sum_next = w_fa_sum;
    end else begin : g_wn
      assign w_sum_next = {w_fa_sum, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy_o       = (r_state == SHIFT);
    case (r_state)
      IDLE:    if (start_i) w_state_next = SHIFT;
      SHIFT:   if (w_last)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      done_o   <= 1'b0;
      S_o      <= '0;
      C_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_a_sh   <= A_i;
            r_b_sh   <= B_i;
            r_carry  <= C_i;
            r_cnt    <= '0;
            r_sum_sh <= '0;
          end
        end
        SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next;
          r_carry  <= w_fa_carry;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            S_o    <= w_sum_next;
            C_o    <= w_fa_carry;
            done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder built around the existing 1-bit full adder cell.
- Loads two WIDTH-bit operands and a carry-in.
- Feeds one bit pair per clock, LSB first, through a single full_adder instance.
- Produces a registered WIDTH-bit sum and carry-out. It is the sequential stage directly upstream of the full adder: it supplies the cell's A/B/carry inputs and recirculates its carry each cycle.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_n_i  input  1  reset; asynchronous, active-low.
- start_i  input  1  request a new addition; sampled only in IDLE.
- A_i  input  WIDTH  operand A; captured on the accepted start.
- B_i  input  WIDTH  operand B; captured on the accepted start.
- C_i  input  1  carry-in; captured on the accepted start.
- busy_o  output  1  high while an addition is in progress.
- done_o  output  1  one-cycle pulse: S_o/C_o just updated.
- S_o  output  WIDTH  registered sum; holds until the next completion.
- C_o  output  1  registered carry-out; holds until the next completion.

Behaviour:
- Reset (rst_n_i low, any time, asynchronous):
  - state=IDLE; busy_o=0, done_o=0, S_o=0, C_o=0.
  - Shift registers, carry flop and counter all cleared.
  - Reset mid-SHIFT aborts the operation; no done_o is produced.
- FSM states: IDLE, SHIFT.
- IDLE:
  - If start_i=1, load a_sh<=A_i, b_sh<=B_i, carry<=C_i, cnt<=0, sum_sh<=0, go to SHIFT.
  - busy_o goes high on the next cycle.
- SHIFT, each cycle:
  - The full_adder is driven with A=a_sh[0], B=b_sh[0], C=carry.
  - a_sh and b_sh shift right by one.
  - sum_sh shifts right by one, with the full_adder sum bit entering at bit WIDTH-1.
  - carry<=full_adder carry-out; cnt<=cnt+1.
- Completion, on the edge where cnt==WIDTH-1:
  - S_o<={fa_sum, sum_sh[WIDTH-1:1]}, C_o<=fa_carry, done_o<=1.
  - Return to IDLE; busy_o<=0.
- Latency: start accepted at edge E0; done_o is high during the cycle after edge E_WIDTH; S_o/C_o are valid from then on.
- Throughput: one result per WIDTH+1 cycles. start_i may be high in the same cycle done_o is high (state is IDLE), giving back-to-back operation.
- start_i in SHIFT is ignored: it is not queued, and A_i/B_i/C_i changes have no effect.
- done_o is a registered pulse, exactly one cycle wide, and deasserts the following edge unconditionally.
- Arithmetic: {C_o,S_o} == A_i + B_i + C_i, modulo 2^(WIDTH+1); there is no overflow flag beyond C_o.
- WIDTH=1: a single SHIFT cycle, which is both the first and the completion cycle.
- Outputs are never X after reset; S_o/C_o change only on a completion edge or on reset.

Decomposition:
- Small shared package, adder_pkg:
  - FSM state encoding: IDLE=1'b0, SHIFT=1'b1.
  - Default WIDTH constant.
- One sub-module: the existing full_adder, instantiated once as the bit-slice datapath.
- Shift registers, counter and FSM stay in serial_adder.

Test Plan:
- Reset then idle: rst_n_i low 3 cycles, release, start_i=0 for 20 cycles -> busy_o=0, done_o=0, S_o=8'h00, C_o=0 throughout.
- Basic add: A_i=8'h35, B_i=8'h4A, C_i=0, start pulse -> busy_o high 8 cycles, done_o pulse 8 cycles after the start edge, S_o=8'h7F, C_o=0.
- Full carry ripple: A_i=8'hFF, B_i=8'h01, C_i=0 -> S_o=8'h00, C_o=1. Also A_i=8'hFF, B_i=8'hFF, C_i=1 -> S_o=8'hFF, C_o=1.
- Start while busy: start with A=8'h10, B=8'h20; reissue start with A=8'hAA, B=8'h55 at SHIFT cycle 3 -> exactly one done_o, S_o=8'h30, C_o=0.
- Back-to-back and reset abort:
  - Start in the done_o cycle with A=8'h01, B=8'h01 -> second done_o exactly 9 cycles after the first, S_o=8'h02.
  - Assert rst_n_i mid-SHIFT -> outputs clear immediately, no done_o.
- Exhaustive sweep at WIDTH=4: all 512 {A,B,C_i} combinations -> {C_o,S_o} equals the reference sum every time, with done_o spacing of 5 cycles.
